// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- next-PC controller for the instruction-fetch stage.
//
// Holds the architectural fetch PC and offers it to IF over a valid/ready
// handshake, stepping by 4 on each accepted PC. Trap and branch/jump redirects
// override sequential fetch and raise a one-cycle flush. Also provides a
// halt/resume mechanism and a saturating count of applied redirects.
//
// Ports:
//   i_clk           single clock, all state updates on posedge
//   i_rst           synchronous reset, active-high
//   i_stall         hazard-unit stall, suppresses o_pc_valid
//   i_br_valid      EX branch-taken / jal / jalr redirect request
//   i_br_target     redirect target for i_br_valid
//   i_trap_valid    trap/exception redirect request (highest priority)
//   i_trap_target   trap vector
//   i_halt_req      halt request (ebreak retired)
//   i_resume        leave HALT at the held PC
//   o_pc_out        PC offered to IF
//   o_pc_valid      o_pc_out valid (IF in_valid)
//   i_pc_ready      IF in_ready
//   o_flush         one-cycle flush pulse to IF and IF/ID
//   o_halted        high while in HALT
//   o_redirect_cnt  count of applied redirects, saturating at all-ones
//   o_state         current FSM state (0 BOOT, 1 RUN, 2 HALT) for debug
//
// Handshake: a PC transfer happens on a rising edge where o_pc_valid and
// i_pc_ready are both high. o_pc_valid does not depend on i_pc_ready, and
// o_pc_out is stable while o_pc_valid is high and no redirect occurs.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_br_valid,
  input  logic [31:0]      i_br_target,
  input  logic             i_trap_valid,
  input  logic [31:0]      i_trap_target,
  input  logic             i_halt_req,
  input  logic             i_resume,
  output logic [31:0]      o_pc_out,
  output logic             o_pc_valid,
  input  logic             i_pc_ready,
  output logic             o_flush,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_redirect_cnt,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_fetch_pc;
  logic             r_flush;
  logic             r_halted;
  logic [CNT_W-1:0] r_redirect_cnt;

  logic        w_take_trap;
  logic        w_take_br;
  logic        w_redirect;
  logic        w_accept;
  logic [31:0] w_target;

  always_comb begin
    w_take_trap = 1'b0;
    w_take_br   = 1'b0;
    w_redirect  = 1'b0;
    w_accept    = 1'b0;
    w_target    = i_br_target;
    o_pc_valid  = (r_state == ST_RUN) && !i_stall;
    // Traps are honoured in RUN and HALT; branches only in RUN.
    w_take_trap = i_trap_valid && (r_state != ST_BOOT);
    w_take_br   = i_br_valid && (r_state == ST_RUN) && !i_trap_valid;
    w_redirect  = w_take_trap || w_take_br;
    if (i_trap_valid) begin
      w_target = i_trap_target;
    end
    w_accept    = o_pc_valid && i_pc_ready;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_BOOT;
      r_fetch_pc     <= RESET_PC;
      r_flush        <= 1'b0;
      r_halted       <= 1'b0;
      r_redirect_cnt <= '0;
    end else begin
      r_flush <= w_redirect;

      // A redirect wins over the handshake; low two bits are forced to zero
      // so the fetch PC stays word aligned.
      if (w_redirect) begin
        r_fetch_pc <= w_target & 32'hFFFF_FFFC;
        if (!(&r_redirect_cnt)) begin
          r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
        end
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      case (r_state)
        ST_BOOT: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
        ST_RUN: begin
          // halt_req beats resume here; any same-cycle redirect is still
          // applied above before HALT is entered.
          if (i_halt_req) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end
        end
        ST_HALT: begin
          // resume beats halt_req; a trap also restarts fetch.
          if (i_resume || i_trap_valid) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_BOOT;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc_out       = r_fetch_pc;
  assign o_flush        = r_flush;
  assign o_halted       = r_halted;
  assign o_redirect_cnt = r_redirect_cnt;
  assign o_state        = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        halted;
  logic [15:0] redirect_cnt;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall        (stall),
    .i_br_valid     (br_valid),
    .i_br_target    (br_target),
    .i_trap_valid   (trap_valid),
    .i_trap_target  (trap_target),
    .i_halt_req     (halt_req),
    .i_resume       (resume),
    .o_pc_out       (pc_out),
    .o_pc_valid     (pc_valid),
    .i_pc_ready     (pc_ready),
    .o_flush        (flush),
    .o_halted       (halted),
    .o_redirect_cnt (redirect_cnt),
    .o_state        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode is 0 boot, 1 running, 2 halted.
  int          m_mode;
  int          m_prev;
  logic [31:0] m_pc;
  logic        m_flush;
  int          m_cnt;
  logic        m_live = 1'b0;
  logic        m_trap_ok;
  logic        m_br_ok;
  logic        m_xfer;

  always @(posedge clk) begin
    if (rst) begin
      m_mode  = 0;
      m_pc    = 32'h0;
      m_flush = 1'b0;
      m_cnt   = 0;
      m_live  = 1'b1;
    end else if (m_live) begin
      m_prev    = m_mode;
      m_trap_ok = trap_valid && (m_prev != 0);
      m_br_ok   = br_valid && (m_prev == 1) && !trap_valid;
      m_xfer    = (m_prev == 1) && !stall && pc_ready;
      m_flush   = m_trap_ok || m_br_ok;
      if (m_trap_ok)   m_pc = trap_target & 32'hFFFF_FFFC;
      else if (m_br_ok) m_pc = br_target & 32'hFFFF_FFFC;
      else if (m_xfer)  m_pc = m_pc + 32'd4;
      if (m_flush && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (m_prev == 0) m_mode = 1;
      else if (m_prev == 1 && halt_req) m_mode = 2;
      else if (m_prev == 2 && (resume || trap_valid)) m_mode = 1;
    end
  end

  // Per-cycle compare, mid-cycle when outputs and inputs are stable.
  always @(negedge clk) begin
    if (m_live) begin
      check("pc_out", pc_out, m_pc);
      check("pc_valid", {31'b0, pc_valid}, {31'b0, (m_mode == 1) && !stall});
      check("flush", {31'b0, flush}, {31'b0, m_flush});
      check("halted", {31'b0, halted}, {31'b0, m_mode == 2});
      check("redirect_cnt", {16'b0, redirect_cnt}, m_cnt[31:0]);
    end
  end

  // driver: one rising edge, then settle; inputs change here, never on an edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0;
    trap_valid = 1'b0; trap_target = '0; halt_req = 1'b0; resume = 1'b0;
    pc_ready = 1'b0;
    step();
    step();
    check("rst_pc", pc_out, 32'h0);
    check("rst_valid", {31'b0, pc_valid}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_cnt", {16'b0, redirect_cnt}, 32'h0);
    check("rst_state", {30'b0, state}, 32'h0);

    // release reset: BOOT for one cycle, then sequential fetch
    rst = 1'b0; pc_ready = 1'b1;
    #1;
    check("boot_valid", {31'b0, pc_valid}, 32'h0);
    step(); check("seq0", pc_out, 32'h0); check("seq0_valid", {31'b0, pc_valid}, 32'h1);
    step(); check("seq1", pc_out, 32'h4);
    step(); check("seq2", pc_out, 32'h8);
    step(); check("seq3", pc_out, 32'hC);
    step(); check("seq4", pc_out, 32'h10);

    // stall for three cycles at 0x10
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc_out, 32'h10);
      check("stall_valid", {31'b0, pc_valid}, 32'h0);
    end
    stall = 1'b0;
    #1;
    check("unstall_valid", {31'b0, pc_valid}, 32'h1);
    step(); check("unstall_pc", pc_out, 32'h14);

    // trap beats branch
    br_valid = 1'b1; br_target = 32'h203; trap_valid = 1'b1; trap_target = 32'h80;
    step();
    check("prio_pc", pc_out, 32'h80);
    check("prio_flush", {31'b0, flush}, 32'h1);
    check("prio_cnt", {16'b0, redirect_cnt}, 32'h1);
    br_valid = 1'b0; trap_valid = 1'b0;
    step();
    check("prio_flush_drop", {31'b0, flush}, 32'h0);
    check("prio_next_pc", pc_out, 32'h84);

    // move to 0x40, then halt with the handshake held off
    br_valid = 1'b1; br_target = 32'h40;
    step(); check("br_pc", pc_out, 32'h40); check("br_cnt", {16'b0, redirect_cnt}, 32'h2);
    br_valid = 1'b0; halt_req = 1'b1; stall = 1'b1;
    step();
    check("halt_halted", {31'b0, halted}, 32'h1);
    check("halt_pc", pc_out, 32'h40);
    check("halt_state", {30'b0, state}, 32'h2);
    halt_req = 1'b0; stall = 1'b0;
    #1;
    check("halt_valid", {31'b0, pc_valid}, 32'h0);
    step(); check("halt_hold", pc_out, 32'h40);

    // resume with an ignored branch: restart at held PC, no flush
    resume = 1'b1; br_valid = 1'b1; br_target = 32'h500;
    step();
    check("resume_halted", {31'b0, halted}, 32'h0);
    check("resume_pc", pc_out, 32'h40);
    check("resume_flush", {31'b0, flush}, 32'h0);
    check("resume_cnt", {16'b0, redirect_cnt}, 32'h2);

    // halt again, leave via trap
    resume = 1'b0; br_valid = 1'b0; pc_ready = 1'b0; halt_req = 1'b1;
    step(); check("halt2", {31'b0, halted}, 32'h1);
    halt_req = 1'b0; trap_valid = 1'b1; trap_target = 32'h123;
    step();
    check("htrap_pc", pc_out, 32'h120);
    check("htrap_flush", {31'b0, flush}, 32'h1);
    check("htrap_halted", {31'b0, halted}, 32'h0);
    check("htrap_cnt", {16'b0, redirect_cnt}, 32'h3);
    trap_valid = 1'b0;

    // halt_req with resume: halts in RUN, resumes in HALT
    halt_req = 1'b1; resume = 1'b1;
    step(); check("both_run", {31'b0, halted}, 32'h1);
    step(); check("both_halt", {31'b0, halted}, 32'h0);
    halt_req = 1'b0; resume = 1'b0;

    // wrap at top of address space
    br_valid = 1'b1; br_target = 32'hFFFF_FFFF;
    step(); check("wrap_load", pc_out, 32'hFFFF_FFFC);
    br_valid = 1'b0; pc_ready = 1'b1;
    step(); check("wrap_pc", pc_out, 32'h0);

    // reset overrides a simultaneous branch
    rst = 1'b1; br_valid = 1'b1; br_target = 32'h300;
    step();
    check("rstbr_pc", pc_out, 32'h0);
    check("rstbr_flush", {31'b0, flush}, 32'h0);
    check("rstbr_cnt", {16'b0, redirect_cnt}, 32'h0);
    check("rstbr_state", {30'b0, state}, 32'h0);
    rst = 1'b0; br_valid = 1'b0;
    step();

    // counter saturation
    br_valid = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      br_target = 32'($urandom_range(0, 32'h0FFF_FFFF));
      step();
    end
    check("cnt_near_sat", {16'b0, redirect_cnt}, 32'hFFFE);
    for (int i = 0; i < 4466; i++) begin
      br_target = 32'($urandom_range(0, 32'h0FFF_FFFF));
      step();
    end
    check("cnt_sat", {16'b0, redirect_cnt}, 32'hFFFF);
    check("cnt_sat_flush", {31'b0, flush}, 32'h1);
    br_valid = 1'b0;
    step();
    check("cnt_sat_hold", {16'b0, redirect_cnt}, 32'hFFFF);
    check("cnt_flush_drop", {31'b0, flush}, 32'h0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
